// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and latency constants for the data memory sequencer
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, DONE} state_t;
  typedef enum logic {OWN_CORE, OWN_HOST} owner_t;

  // Cycles from the grant edge to the done cycle
  localparam int LAT_WR_SINGLE = 2;
  localparam int LAT_WR_PAIR   = 3;
  localparam int LAT_RD_SINGLE = 3;
  localparam int LAT_RD_PAIR   = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; bit 0 is the core, bit 1 the host
module rr_arb2 (
  input  logic       CLK,
  input  logic       start_n,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic [1:0] gnt
);

  logic last_host;

  always_comb begin
    gnt = 2'b00;
    if (gnt_en) begin
      if (req == 2'b11) gnt = last_host ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Resetting to "host went last" lets the core win the first tie
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n)  last_host <= 1'b1;
    else if (|gnt) last_host <= gnt[1];
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences core byte/pair and host byte accesses onto the single-port data memory
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          start_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic          core_pair,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata_msw,
  input  logic [DW-1:0] core_wdata_lsw,
  output logic [DW-1:0] core_rdata_msw,
  output logic [DW-1:0] core_rdata_lsw,
  output logic          core_done,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state, state_nxt;
  owner_t        owner;
  logic          we_q, pair_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wmsw_q, wlsw_q;
  logic [DW-1:0] core_rmsw_q, core_rlsw_q, host_rdata_q;
  logic [1:0]    gnt;

  rr_arb2 u_arb (
    .CLK     (CLK),
    .start_n (start_n),
    .req     ({host_req, core_req}),
    .gnt_en  (state == IDLE),
    .gnt     (gnt)
  );

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: if (|gnt) state_nxt = ACC0;
      ACC0: begin
        mem_addr = addr_q;
        mem_we   = we_q;
        mem_re   = ~we_q;
        if (we_q) mem_wdata = pair_q ? wmsw_q : wlsw_q;
        if (pair_q)    state_nxt = ACC1;
        else if (we_q) state_nxt = DONE;
        else           state_nxt = WAIT;
      end
      ACC1: begin
        mem_addr = addr_q + 1'b1;
        mem_we   = we_q;
        mem_re   = ~we_q;
        if (we_q) mem_wdata = wlsw_q;
        state_nxt = we_q ? DONE : WAIT;
      end
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at the grant; later input changes are ignored
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      owner  <= OWN_CORE;
      we_q   <= 1'b0;
      pair_q <= 1'b0;
      addr_q <= '0;
      wmsw_q <= '0;
      wlsw_q <= '0;
    end else if (state == IDLE && gnt[0]) begin
      owner  <= OWN_CORE;
      we_q   <= core_we;
      pair_q <= core_pair;
      addr_q <= core_addr;
      wmsw_q <= core_wdata_msw;
      wlsw_q <= core_wdata_lsw;
    end else if (state == IDLE && gnt[1]) begin
      owner  <= OWN_HOST;
      we_q   <= host_we;
      pair_q <= 1'b0;
      addr_q <= host_addr;
      wmsw_q <= '0;
      wlsw_q <= host_wdata;
    end
  end

  // mem_rdata lags mem_re by one cycle, so ACC1 sees the MSW and WAIT the last byte
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      core_rmsw_q  <= '0;
      core_rlsw_q  <= '0;
      host_rdata_q <= '0;
    end else if (state == ACC1 && !we_q) begin
      core_rmsw_q <= mem_rdata;
    end else if (state == WAIT) begin
      if (owner == OWN_CORE) core_rlsw_q  <= mem_rdata;
      else                   host_rdata_q <= mem_rdata;
    end
  end

  assign core_rdata_msw = core_rmsw_q;
  assign core_rdata_lsw = core_rlsw_q;
  assign host_rdata     = host_rdata_q;
  assign core_done      = (state == DONE) && (owner == OWN_CORE);
  assign host_done      = (state == DONE) && (owner == OWN_HOST);
  assign core_stall     = core_req & ~core_done;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic       CLK = 1'b0;
  logic       start_n = 1'b0;
  logic       core_req = 1'b0, core_we = 1'b0, core_pair = 1'b0;
  logic [7:0] core_addr = 8'h00, core_wdata_msw = 8'h00, core_wdata_lsw = 8'h00;
  logic [7:0] core_rdata_msw, core_rdata_lsw;
  logic       core_done, core_stall;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       host_done;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re, busy;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [256] = '{default: 8'h00};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       we, pair;
    logic [7:0] addr, msw, lsw;
    int         lat;
    logic       chk_msw;
    logic [7:0] e_msw, e_lsw;
  } vec_t;

  typedef struct {
    logic [7:0] msw, lsw;
    logic       chk_msw;
  } exp_t;

  vec_t        vecs [9];
  exp_t        sb [$];
  logic [15:0] wlog [$];

  dmem_access_ctrl #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .start_n(start_n),
    .core_req(core_req), .core_we(core_we), .core_pair(core_pair), .core_addr(core_addr),
    .core_wdata_msw(core_wdata_msw), .core_wdata_lsw(core_wdata_lsw),
    .core_rdata_msw(core_rdata_msw), .core_rdata_lsw(core_rdata_lsw),
    .core_done(core_done), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_done(host_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge CLK) begin
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    if (mem_we && mem_re) begin
      checks++;
      failures++;
      $display("FAIL we_re_overlap actual=both required=one");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_core(input vec_t v, input string name, input bit perturb);
    int         lat = 0;
    bit         done_seen = 0;
    bit         stall_ok = 1;
    exp_t       e;
    logic [7:0] a1;
    @(negedge CLK);
    wlog.delete();
    core_req = 1'b1; core_we = v.we; core_pair = v.pair; core_addr = v.addr;
    core_wdata_msw = v.msw; core_wdata_lsw = v.lsw;
    if (!v.we) sb.push_back('{msw: v.e_msw, lsw: v.e_lsw, chk_msw: v.chk_msw});
    while (!done_seen && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (perturb && lat == 1) begin
        core_addr = v.addr + 8'd1; core_wdata_msw = ~v.msw; core_wdata_lsw = ~v.lsw;
      end
      if (core_done) done_seen = 1;
      else if (!core_stall) stall_ok = 0;
    end
    chk({name, "_done"}, done_seen, 1);
    chk({name, "_lat"}, lat, v.lat);
    chk({name, "_stall_done"}, core_stall, 0);
    chk({name, "_stall_held"}, stall_ok, 1);
    core_req = 1'b0;
    if (!v.we && sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_rlsw"}, core_rdata_lsw, e.lsw);
      if (e.chk_msw) chk({name, "_rmsw"}, core_rdata_msw, e.msw);
    end
    if (v.we) begin
      a1 = v.addr + 8'd1;
      chk({name, "_wcount"}, wlog.size(), v.pair ? 2 : 1);
      if (wlog.size() > 0) chk({name, "_w0"}, wlog[0], {v.addr, v.pair ? v.msw : v.lsw});
      if (v.pair && wlog.size() > 1) chk({name, "_w1"}, wlog[1], {a1, v.lsw});
    end
  endtask

  task automatic run_host(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] e_rdata, input int e_lat, input string name);
    int lat = 0;
    bit done_seen = 0;
    @(negedge CLK);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    while (!done_seen && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (host_done) done_seen = 1;
    end
    host_req = 1'b0;
    chk({name, "_done"}, done_seen, 1);
    chk({name, "_lat"}, lat, e_lat);
    if (!we) chk({name, "_rdata"}, host_rdata, e_rdata);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    start_n = 1'b0;
    repeat (2) @(negedge CLK);
    start_n = 1'b1;
  endtask

  initial begin
    int   order [$];
    int   n;
    bit   quiet;
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 2, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h12, 8'h34, 3, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h20, 8'h00, 8'h00, 4, 1'b1, 8'h12, 8'h34};
    vecs[3] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'hAB, 8'hCD, 3, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 4, 1'b1, 8'hAB, 8'hCD};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'hCD};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 2, 1'b0, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 4, 1'b1, 8'hAB, 8'h5A};

    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", {core_done, host_done}, 0);
    chk("rst_rdata", {core_rdata_msw, core_rdata_lsw, host_rdata}, 0);
    start_n = 1'b1;

    for (int i = 0; i < 9; i++) run_core(vecs[i], $sformatf("vec%0d", i), 1'b0);

    run_host(1'b1, 8'h80, 8'hE7, 8'h00, 2, "host_wr");
    run_host(1'b0, 8'h21, 8'h00, 8'h34, 3, "host_rd");
    v = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 3, 1'b0, 8'h00, 8'hE7};
    run_core(v, "core_rd_hostdata", 1'b0);

    // Latched fields: the memory must only see the values present at the grant
    v = '{1'b1, 1'b0, 8'h70, 8'h00, 8'h3C, 2, 1'b0, 8'h00, 8'h00};
    run_core(v, "latched_single", 1'b1);
    v = '{1'b1, 1'b1, 8'h72, 8'h44, 8'h55, 3, 1'b0, 8'h00, 8'h00};
    run_core(v, "latched_pair", 1'b1);

    // Tie after reset: core first, then alternation while both are held
    do_reset();
    @(negedge CLK);
    core_req = 1'b1; core_we = 1'b1; core_pair = 1'b0; core_addr = 8'h50; core_wdata_lsw = 8'h77;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    n = 0;
    while (order.size() < 3 && n < 40) begin
      @(negedge CLK);
      n++;
      if (core_done) order.push_back(0);
      if (host_done) begin
        order.push_back(1);
        chk("tie_host_rdata", host_rdata, 8'hA5);
        chk("tie_core_stall_behind_host", core_stall, 1);
      end
    end
    core_req = 1'b0; host_req = 1'b0;
    chk("tie_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("tie_first_core", order[0], 0);
      chk("tie_second_host", order[1], 1);
      chk("tie_third_core", order[2], 0);
    end
    chk("tie_mem_50", mem[8'h50], 8'h77);

    // Reset in ACC1 of a pair store: outputs drop at once, no done, LSW never written
    @(negedge CLK);
    @(negedge CLK);
    core_req = 1'b1; core_we = 1'b1; core_pair = 1'b1; core_addr = 8'h60;
    core_wdata_msw = 8'h99; core_wdata_lsw = 8'h88;
    repeat (2) @(negedge CLK);
    chk("acc1_mem_we", mem_we, 1);
    chk("acc1_mem_addr", mem_addr, 8'h61);
    start_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_re", mem_re, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_done", core_done, 0);
    core_req = 1'b0;
    @(negedge CLK);
    start_n = 1'b1;
    quiet = 1;
    repeat (4) begin
      @(negedge CLK);
      if (core_done || host_done || busy) quiet = 0;
    end
    chk("abort_no_done", quiet, 1);
    v = '{1'b0, 1'b1, 8'h60, 8'h00, 8'h00, 4, 1'b1, 8'h99, 8'h00};
    run_core(v, "after_abort", 1'b0);

    chk("sb_empty", sb.size(), 0);
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
